// File: rtl/mxint8_unpack_if.sv
// Handshake bundle for mxint8_unpack: MX block in (i_*), serialized float32 beats out (o_*).
// Signal names are from the decoder's point of view; the decoder uses the slave modport.
interface mxint8_unpack_if #(
    parameter int BLOCK_SIZE           = 32,
    parameter int SCALE_WIDTH          = 8,
    parameter int MXINT8_ELEMENT_WIDTH = 8,
    parameter int FLOAT32_WIDTH        = 32
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);

    logic                            i_valid;
    logic                            o_ready;
    logic [SCALE_WIDTH-1:0]          i_scale;
    logic [MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements [BLOCK_SIZE-1:0];
    logic                            o_valid;
    logic                            i_ready;
    logic [FLOAT32_WIDTH-1:0]        o_float32;
    logic [IDX_W-1:0]                o_index;
    logic                            o_last;

    modport slave (
        input  i_valid, i_scale, i_mxint8_elements, i_ready,
        output o_ready, o_valid, o_float32, o_index, o_last
    );

    modport master (
        output i_valid, i_scale, i_mxint8_elements, i_ready,
        input  o_ready, o_valid, o_float32, o_index, o_last
    );
endinterface

// File: rtl/mxint8_unpack.sv
// Serializing MXINT8 -> float32 decoder: one captured MX block out as BLOCK_SIZE exact float32 beats.
// Define MXINT8_UNPACK_SUBNORMAL_EN to emit exact subnormals; otherwise tiny results flush to signed zero.
//
// state  | meaning
// IDLE   | o_ready high (from the cycle after reset), waiting for a block
// STREAM | presenting beats of the captured block, input ignored
module mxint8_unpack #(
    parameter int BLOCK_SIZE = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mxint8_unpack_if.slave bus
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q, state_d;
    logic [7:0]       scale_q;
    logic [7:0]       elems_q [BLOCK_SIZE];
    logic             load, advance, finish, ready_d;
    logic [IDX_W-1:0] idx_next;

    // value = e * 2^(s-127) * 2^-6, exact; m is |e| so -128 becomes 0x80
    function automatic logic [31:0] decode(input logic [7:0] s, input logic [7:0] e);
        logic              sign;
        logic [7:0]        m;
        logic [2:0]        p;
        logic signed [9:0] exp_b;
        logic [6:0]        frac7;
`ifdef MXINT8_UNPACK_SUBNORMAL_EN
        logic [22:0]       sub;
`endif
        sign  = e[7];
        m     = sign ? 8'(8'd0 - e) : e;
        p     = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) p = 3'(i);
        exp_b = $signed({2'b00, s}) + $signed({7'd0, p}) - 10'sd6;
        frac7 = 7'(m << (3'd7 - p));
`ifdef MXINT8_UNPACK_SUBNORMAL_EN
        // s is at most 6 whenever this is selected, so the low scale bits suffice
        sub   = {15'd0, m} << (6'(s[4:0]) + 6'd16);
`endif
        if (s == 8'hFF)        return 32'h7FC0_0000;
        if (m == 8'd0)         return 32'h0000_0000;
        if (exp_b >= 10'sd255) return {sign, 8'hFF, 23'd0};
        if (exp_b <= 10'sd0) begin
`ifdef MXINT8_UNPACK_SUBNORMAL_EN
            return {sign, 8'd0, sub};
`else
            return {sign, 31'd0};
`endif
        end
        return {sign, exp_b[7:0], frac7, 16'd0};
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid && bus.o_ready) state_d = STREAM;
            STREAM:  if (bus.o_valid && bus.i_ready && bus.o_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load     = (state_q == IDLE) && bus.i_valid && bus.o_ready;
        advance  = (state_q == STREAM) && bus.o_valid && bus.i_ready && !bus.o_last;
        finish   = (state_q == STREAM) && bus.o_valid && bus.i_ready && bus.o_last;
        ready_d  = (state_d == IDLE);
        idx_next = bus.o_index + 1'b1;
    end

    // Captured copy lets the upstream reuse its inputs right after acceptance
    always_ff @(posedge i_clk) begin
        if (load) begin
            scale_q <= bus.i_scale;
            for (int i = 0; i < BLOCK_SIZE; i++)
                elems_q[i] <= bus.i_mxint8_elements[i];
        end
    end

    // o_ready is a flop so it stays low through reset and rises one edge later
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_ready   <= 1'b0;
            bus.o_valid   <= 1'b0;
            bus.o_float32 <= 32'd0;
            bus.o_index   <= '0;
            bus.o_last    <= 1'b0;
        end else begin
            bus.o_ready <= ready_d;
            if (load) begin
                bus.o_valid   <= 1'b1;
                bus.o_float32 <= decode(bus.i_scale, bus.i_mxint8_elements[0]);
                bus.o_index   <= '0;
                bus.o_last    <= (BLOCK_SIZE == 1);
            end else if (advance) begin
                bus.o_float32 <= decode(scale_q, elems_q[idx_next]);
                bus.o_index   <= idx_next;
                bus.o_last    <= (idx_next == IDX_W'(BLOCK_SIZE - 1));
            end else if (finish) begin
                bus.o_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mxint8_unpack.sv
// Directed bench for mxint8_unpack: table of single-element blocks plus hand-written block sequences.
module tb_mxint8_unpack;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    mxint8_unpack_if bus ();
    mxint8_unpack dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  s;
        int          idx;
        logic [7:0]  e;
        logic [31:0] x;
    } vec_t;

    vec_t        vecs [16];
    logic [7:0]  el   [32];
    logic [7:0]  elb  [32];
    logic [31:0] xp   [32];
    logic [31:0] xpb  [32];

`ifdef MXINT8_UNPACK_SUBNORMAL_EN
    localparam logic [31:0] X_S0_P64  = 32'h0040_0000;
    localparam logic [31:0] X_S0_M64  = 32'h8040_0000;
    localparam logic [31:0] X_S5_P3   = 32'h0060_0000;
    localparam logic [31:0] X_S6_P1   = 32'h0040_0000;
`else
    localparam logic [31:0] X_S0_P64  = 32'h0000_0000;
    localparam logic [31:0] X_S0_M64  = 32'h8000_0000;
    localparam logic [31:0] X_S5_P3   = 32'h0000_0000;
    localparam logic [31:0] X_S6_P1   = 32'h0000_0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic [7:0] s, input logic [7:0] e [32]);
        bus.i_scale = s;
        for (int j = 0; j < 32; j++) bus.i_mxint8_elements[j] = e[j];
        bus.i_valid = 1'b1;
    endtask

    // Call near a negedge; returns 1 time unit after the accepting edge with i_valid dropped
    task automatic accept(input logic [7:0] s, input logic [7:0] e [32]);
        int n = 0;
        drive(s, e);
        while (!bus.o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("accept_wait_ready", 32'(bus.o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic collect(input logic [31:0] exp [32], input bit rnd, input string tag);
        int k   = 0;
        int cyc = 0;
        while (k < 32 && cyc < 1000) begin
            @(negedge i_clk);
            cyc++;
            check($sformatf("%s_valid_b%0d", tag, k), 32'(bus.o_valid), 32'd1);
            check($sformatf("%s_ready_b%0d", tag, k), 32'(bus.o_ready), 32'd0);
            check($sformatf("%s_value_b%0d", tag, k), bus.o_float32, exp[k]);
            check($sformatf("%s_index_b%0d", tag, k), 32'(bus.o_index), 32'(k));
            check($sformatf("%s_last_b%0d", tag, k), 32'(bus.o_last), 32'(k == 31));
            if (rnd && cyc < 300) bus.i_ready = ($urandom_range(0, 2) != 0);
            else                  bus.i_ready = 1'b1;
            if (bus.i_ready) k++;
        end
        check($sformatf("%s_beats_done", tag), 32'(k), 32'd32);
        @(negedge i_clk);
        check($sformatf("%s_valid_after", tag), 32'(bus.o_valid), 32'd0);
        check($sformatf("%s_ready_after", tag), 32'(bus.o_ready), 32'd1);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'd127, 0,  8'h40, 32'h3F80_0000};
        vecs[1]  = '{8'd127, 0,  8'h80, 32'hC000_0000};
        vecs[2]  = '{8'd127, 1,  8'h01, 32'h3C80_0000};
        vecs[3]  = '{8'd127, 3,  8'h7F, 32'h3FFE_0000};
        vecs[4]  = '{8'hFF,  5,  8'h37, 32'h7FC0_0000};
        vecs[5]  = '{8'd254, 0,  8'h80, 32'hFF80_0000};
        vecs[6]  = '{8'd254, 31, 8'h7F, 32'h7F7E_0000};
        vecs[7]  = '{8'd0,   0,  8'h40, X_S0_P64};
        vecs[8]  = '{8'd0,   1,  8'hC0, X_S0_M64};
        vecs[9]  = '{8'd130, 7,  8'hFF, 32'hBE00_0000};
        vecs[10] = '{8'd5,   2,  8'h03, X_S5_P3};
        vecs[11] = '{8'd6,   4,  8'h01, X_S6_P1};
        vecs[12] = '{8'd7,   4,  8'h01, 32'h0080_0000};
        vecs[13] = '{8'd0,   9,  8'h80, 32'h8080_0000};
        vecs[14] = '{8'd253, 30, 8'h80, 32'hFF00_0000};
        vecs[15] = '{8'd127, 10, 8'h55, 32'h3FAA_0000};

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_scale = 8'd0;
        for (int j = 0; j < 32; j++) bus.i_mxint8_elements[j] = 8'd0;

        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_value", bus.o_float32, 32'd0);
        check("rst_index", 32'(bus.o_index), 32'd0);
        check("rst_last",  32'(bus.o_last), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_release_ready", 32'(bus.o_ready), 32'd1);
        check("rst_release_valid", 32'(bus.o_valid), 32'd0);

        // 1.0 everywhere, full-rate stream
        for (int j = 0; j < 32; j++) begin el[j] = 8'h40; xp[j] = 32'h3F80_0000; end
        accept(8'd127, el);
        collect(xp, 1'b0, "ones");

        for (int j = 0; j < 32; j++) begin el[j] = 8'h00; xp[j] = 32'h0; end
        el[0] = 8'h80; el[1] = 8'h01; el[3] = 8'h7F;
        xp[0] = 32'hC000_0000; xp[1] = 32'h3C80_0000; xp[3] = 32'h3FFE_0000;
        accept(8'd127, el);
        collect(xp, 1'b0, "mix127");

        for (int j = 0; j < 32; j++) begin el[j] = 8'($urandom); xp[j] = 32'h7FC0_0000; end
        accept(8'hFF, el);
        collect(xp, 1'b0, "nan");

        for (int j = 0; j < 32; j++) begin el[j] = 8'h00; xp[j] = 32'h0; end
        el[0] = 8'h80; el[1] = 8'h7F;
        xp[0] = 32'hFF80_0000; xp[1] = 32'h7F7E_0000;
        accept(8'd254, el);
        collect(xp, 1'b0, "s254");

        for (int j = 0; j < 32; j++) begin el[j] = 8'h00; xp[j] = 32'h0; end
        el[0] = 8'h40; el[1] = 8'hC0;
        xp[0] = X_S0_P64; xp[1] = X_S0_M64;
        accept(8'd0, el);
        collect(xp, 1'b0, "s0");

        for (int v = 0; v < 16; v++) begin
            for (int j = 0; j < 32; j++) begin
                el[j] = 8'h00;
                xp[j] = (vecs[v].s == 8'hFF) ? 32'h7FC0_0000 : 32'h0;
            end
            el[vecs[v].idx] = vecs[v].e;
            xp[vecs[v].idx] = vecs[v].x;
            accept(vecs[v].s, el);
            collect(xp, bit'(v % 2), $sformatf("vec%0d", v));
        end

        // Block A under random backpressure with block B held on the inputs the whole time
        for (int j = 0; j < 32; j++) begin
            case (j % 4)
                0:       begin el[j] = 8'h40; xp[j] = 32'h3F80_0000; end
                1:       begin el[j] = 8'hC0; xp[j] = 32'hBF80_0000; end
                2:       begin el[j] = 8'h01; xp[j] = 32'h3C80_0000; end
                default: begin el[j] = 8'h80; xp[j] = 32'hC000_0000; end
            endcase
            elb[j] = 8'h40;
            xpb[j] = 32'h4000_0000;
        end
        accept(8'd127, el);
        drive(8'd128, elb);
        collect(xp, 1'b1, "heldA");
        accept(8'd128, elb);
        collect(xpb, 1'b1, "heldB");

        // Reset while beat 10 is on the outputs
        accept(8'd127, el);
        bus.i_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge i_clk);
            check($sformatf("pre_rst_index_b%0d", k), 32'(bus.o_index), 32'(k));
            check($sformatf("pre_rst_value_b%0d", k), bus.o_float32, xp[k]);
        end
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_ready", 32'(bus.o_ready), 32'd0);
        check("midrst_value", bus.o_float32, 32'd0);
        check("midrst_index", 32'(bus.o_index), 32'd0);
        check("midrst_last",  32'(bus.o_last), 32'd0);
        i_rst_n = 1'b1;
        bus.i_ready = 1'b0;
        @(negedge i_clk);
        check("postrst_valid", 32'(bus.o_valid), 32'd0);
        check("postrst_ready", 32'(bus.o_ready), 32'd1);
        accept(8'd128, elb);
        collect(xpb, 1'b0, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
